// File: rtl/pci_initiator.sv
// pci_initiator -- bus-master end of the simplified PCI interface.
//
// Accepts a one-shot request (command, address, 1-4 words) from local logic
// and runs one address phase followed by a burst of data phases. Write data
// comes from wdata, read data is collected into rdata. If no target claims
// the cycle within DEVSEL_TIMEOUT data clocks, the cycle ends in master abort.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request pulse, sampled only in IDLE
//   cmd, addr, len    command (PCI_read/PCI_write), address, word count 1-4
//   wdata, be         write words / per-word byte lanes, word i at [32*i +: 32] / [4*i +: 4]
//   rdata             read words, same packing as wdata
//   busy, done, abort transfer in progress / success pulse / master-abort pulse
//   Frame, IRDY       active-low bus controls driven by the initiator
//   CBE, AD           command/byte-enables and address/data, released (z) when idle
//   DEVSEL, TRDY      active-low target claim and target ready
//   state_dbg         current FSM state for observation
//
// Handshake: a data word completes on a posedge where IRDY=0, TRDY=0 and
// DEVSEL=0; any other combination in a data phase holds the bus unchanged.
module pci_initiator #(
  parameter logic [3:0] PCI_read       = 4'b0010,
  parameter logic [3:0] PCI_write      = 4'b0011,
  parameter int         DEVSEL_TIMEOUT = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   cmd,
  input  logic [31:0]  addr,
  input  logic [2:0]   len,
  input  logic [127:0] wdata,
  input  logic [15:0]  be,
  output logic [127:0] rdata,
  output logic         busy,
  output logic         done,
  output logic         abort,
  output logic         Frame,
  output logic         IRDY,
  output logic [3:0]   CBE,
  inout  wire  [31:0]  AD,
  input  logic         DEVSEL,
  input  logic         TRDY,
  output logic [1:0]   state_dbg
);

  localparam int TW = $clog2(DEVSEL_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ABORT} state_t;

  state_t         state;
  logic           is_read;
  logic [1:0]     last_idx;
  logic [1:0]     idx;
  logic [127:0]   wdata_q;
  logic [15:0]    be_q;
  logic [TW-1:0]  tcnt;
  logic           devsel_seen;
  logic [3:0]     cbe_q;
  logic           cbe_oe;
  logic [31:0]    ad_q;
  logic           ad_oe;

  logic           start_ok;
  logic [1:0]     len_last;
  logic [1:0]     nidx;
  logic           xfer;
  logic           timeout_hit;

  assign AD        = ad_oe  ? ad_q  : 32'bz;
  assign CBE       = cbe_oe ? cbe_q : 4'bz;
  assign state_dbg = state;

  assign start_ok = start && ((cmd == PCI_read) || (cmd == PCI_write)) && (len != 3'd0);
  // Index of the last word; lengths above 4 are clamped to 4 words.
  assign len_last = (len >= 3'd4) ? 2'd3 : (len[1:0] - 2'd1);
  assign nidx     = idx + 2'd1;
  assign xfer     = !IRDY && !TRDY && !DEVSEL;
  // Once any DEVSEL=0 has been seen the counter is frozen, so abort can no
  // longer happen for this transfer.
  assign timeout_hit = DEVSEL && !devsel_seen && (tcnt == TW'(DEVSEL_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      is_read     <= 1'b0;
      last_idx    <= 2'd0;
      idx         <= 2'd0;
      wdata_q     <= '0;
      be_q        <= '0;
      tcnt        <= '0;
      devsel_seen <= 1'b0;
      cbe_q       <= 4'd0;
      cbe_oe      <= 1'b0;
      ad_q        <= 32'd0;
      ad_oe       <= 1'b0;
      rdata       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      abort       <= 1'b0;
      Frame       <= 1'b1;
      IRDY        <= 1'b1;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state       <= ADDR;
            busy        <= 1'b1;
            is_read     <= (cmd == PCI_read);
            last_idx    <= len_last;
            wdata_q     <= wdata;
            be_q        <= be;
            idx         <= 2'd0;
            tcnt        <= '0;
            devsel_seen <= 1'b0;
            Frame       <= 1'b0;
            IRDY        <= 1'b1;
            ad_q        <= addr;
            ad_oe       <= 1'b1;
            cbe_q       <= cmd;
            cbe_oe      <= 1'b1;
          end
        end
        ADDR: begin
          state <= DATA;
          IRDY  <= 1'b0;
          cbe_q <= be_q[3:0];
          ad_q  <= wdata_q[31:0];
          // Reads turn the bus around here and never drive AD again.
          ad_oe <= !is_read;
          if (last_idx == 2'd0) Frame <= 1'b1;
        end
        DATA: begin
          if (!DEVSEL)           devsel_seen <= 1'b1;
          else if (!devsel_seen) tcnt        <= tcnt + 1'b1;

          if (timeout_hit) begin
            state <= ABORT;
            Frame <= 1'b1;
          end else if (xfer) begin
            if (is_read) rdata[32*idx +: 32] <= AD;
            if (idx == last_idx) begin
              state  <= IDLE;
              Frame  <= 1'b1;
              IRDY   <= 1'b1;
              cbe_oe <= 1'b0;
              ad_oe  <= 1'b0;
              done   <= 1'b1;
              busy   <= 1'b0;
            end else begin
              idx   <= nidx;
              cbe_q <= be_q[4*nidx +: 4];
              ad_q  <= wdata_q[32*nidx +: 32];
              // Frame goes high together with the final data phase.
              if (nidx == last_idx) Frame <= 1'b1;
            end
          end
        end
        ABORT: begin
          state  <= IDLE;
          IRDY   <= 1'b1;
          cbe_oe <= 1'b0;
          ad_oe  <= 1'b0;
          abort  <= 1'b1;
          busy   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pci_initiator.md
Name: pci_initiator

Overview:
- Bus-master (initiator) end of our simplified PCI interface; the counterpart of the existing PCI target.
- Takes a one-shot transfer request from local logic: command, address, 1-4 words.
- Runs one address phase, then a burst of data phases: drives Frame/IRDY/CBE/AD and obeys the target's DEVSEL/TRDY.
- Write data comes from a local 4-word buffer; read data lands in a local 4-word buffer; master abort is reported if no target claims the cycle.

Parameters:
PCI_read, 4'b0010, read command code
PCI_write, 4'b0011, write command code
DEVSEL_TIMEOUT, 5, data-phase clocks with DEVSEL high before master abort (min 1)

Ports:
clk  input  1  system clock; all state changes on posedge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
cmd  input  4  PCI command; only PCI_read / PCI_write accepted
addr  input  32  target address driven in address phase
len  input  3  words to transfer, 1-4
wdata  input  128  write words; word i = wdata[32*i+31:32*i]
be  input  16  data-phase CBE for word i = be[4*i+3:4*i]
rdata  output  128  read words, same packing as wdata
busy  output  1  high from accepted start until return to IDLE
done  output  1  one-clock pulse on successful completion
abort  output  1  one-clock pulse on master abort
Frame  output  1  active-low frame
IRDY  output  1  active-low initiator ready
CBE  output  4  command (address phase) / byte lanes (data phase)
AD  inout  32  address/data bus
DEVSEL  input  1  active-low target claim
TRDY  input  1  active-low target ready

Behaviour:
- Reset (synchronous, at posedge with rst=1, overriding everything, including mid-transfer):
  - State IDLE; Frame=1, IRDY=1, CBE=4'hz, AD released (z).
  - busy=0, done=0, abort=0, rdata=0, word index and timeout counter cleared; no done/abort pulse on reset.
- States: IDLE, ADDR, DATA, ABORT.
- Start acceptance (IDLE only):
  - start=1, cmd in {PCI_read, PCI_write}, len 1-4: latch cmd/addr/len/wdata/be, go to ADDR.
  - len>4 is clamped to 4.
  - len=0 or any other cmd: start ignored; no bus activity, no pulse.
  - start outside IDLE is ignored.
- ADDR (exactly 1 clock): Frame=0, IRDY=1, AD=addr, CBE=cmd, busy=1.
- DATA entry (next posedge):
  - IRDY=0, CBE=be word0.
  - Write: AD=wdata word0.
  - Read: AD=z from this clock until idle (turnaround); AD is never driven during a read data phase.
  - If len==1, Frame=1 on entry.
- DATA transfer rule: a word completes at a posedge with IRDY=0 and TRDY=0.
  - Read: capture AD into rdata[index].
  - Write: advance to the next word's AD/CBE.
  - Increment index.
  - If the next word is the last one, drive Frame=1 in the same clock as advancing to it.
  - TRDY=1 (wait state): hold AD/CBE/Frame/IRDY unchanged, with no limit.
- Last word completes:
  - Frame=1, IRDY=1, CBE=z, AD=z; done=1 for 1 clock.
  - Return to IDLE; busy=0 in the same clock.
- Master abort:
  - Timeout counter increments each DATA posedge while DEVSEL=1.
  - Once DEVSEL=0 is seen, the counter freezes and abort is impossible for this transfer.
  - When the count reaches DEVSEL_TIMEOUT: go to ABORT with Frame=1, IRDY=0 held.
  - One clock later: IRDY=1, abort=1 pulse, no done, busy=0, IDLE.
  - rdata words already captured are kept.
- TRDY=0 while DEVSEL=1 is ignored; a transfer requires DEVSEL=0.
- Frame is never deasserted before the final data phase, and IRDY is never deasserted while Frame=0.
- Back-to-back: start is accepted in the IDLE clock following done, giving a minimum of one idle clock (Frame=1, IRDY=1) between transactions.
- Latency: for an N-word burst with zero wait states, Frame is low N clocks (1 address + N-1 data), IRDY is low N clocks, and done asserts N+1 clocks after the start is sampled.

Test Plan:
- Write burst:
  - Stimulus: start, cmd=0011, addr=32'h10, len=4, wdata words 1001/1002/1003/1004, be 0000/1111/0000/1111; target with DEVSEL/TRDY low from the first data clock.
  - Required: AD = h10 then 1001..1004; Frame high during word 4; done exactly 5 clocks after start; target memory = 0/1002/0/1004.
- Read burst:
  - Stimulus: after the write burst, cmd=0010, len=4; target returns its memory.
  - Required: AD released after ADDR; rdata words = 0/1002/0/1004; done pulse.
- Wait states:
  - Stimulus: target holds TRDY=1 for 2 clocks before word 2 of a len=3 write.
  - Required: AD/CBE/IRDY stable through the wait; Frame rises only with word 3; done 2 clocks later than with zero waits.
- Master abort:
  - Stimulus: addr=32'h20, no target responds (DEVSEL stays 1).
  - Required: after 5 DATA clocks Frame=1, then IRDY=1; abort=1 pulse; done never asserts.
- Single word and illegal request:
  - Stimulus: len=1 write; separately, cmd=0110 or len=0.
  - Required: len=1 has Frame low 1 clock and IRDY low 1 clock; the illegal start leaves the bus idle with busy=0.
- Reset mid-read:
  - Stimulus: rst=1 for 1 clock during word 2 of 4.
  - Required: at that posedge Frame=1, IRDY=1, AD=z, rdata=0, no done/abort; a new start is then accepted normally.
